// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared types and widths for the SR latch driver
package sr_drv_pkg;

  localparam int CNT_W = 4;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter timing the drive and gap phases
module pulse_timer
  import sr_drv_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Holds at zero until the next load so the FSM can dwell on it safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_driver.sv
// rtl/sr_driver.sv - pulses s/r/en into an external SR latch and checks its feedback
module sr_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic             cmd_set,
  output logic             cmd_ready,
  output logic             s,
  output logic             r,
  output logic             en,
  input  logic             q_fb,
  output logic             q_exp,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

  state_t           state;
  state_t           state_nx;
  logic             cmd_q;
  logic             cmd_nx;
  logic             accept;
  logic             drive_nx;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             fb_bad;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_nx    = accept ? cmd_set : cmd_q;
  assign fb_bad    = (state == CHECK) && (q_fb != q_exp);

  pulse_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = DRIVE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          state_nx = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_nx = CHECK;
        end
      end
      CHECK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign drive_nx = (state_nx == DRIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_q <= 1'b0;
    end else begin
      state <= state_nx;
      cmd_q <= cmd_nx;
    end
  end

  // Latch drives are registered from the next state so they line up with DRIVE exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= 1'b0;
      s  <= 1'b0;
      r  <= 1'b0;
    end else begin
      en <= drive_nx;
      s  <= drive_nx & cmd_nx;
      r  <= drive_nx & ~cmd_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_exp    <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (state == DRIVE && tmr_zero) begin
        q_exp <= cmd_q;
      end
      mismatch <= fb_bad;
      if (fb_bad && err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_driver.sv
// tb/tb_sr_driver.sv - randomized and directed checks of sr_driver against a cycle-offset model
module tb_sr_driver;

  localparam int PW  = 2;
  localparam int GW  = 1;
  localparam int CHK = PW + GW + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_set = 1'b0;
  logic       q_fb = 1'b0;
  logic       cmd_ready;
  logic       s;
  logic       r;
  logic       en;
  logic       q_exp;
  logic       mismatch;
  logic [7:0] err_cnt;

  logic q_latch = 1'b0;

  int tests = 0;
  int fails = 0;

  // Model: ph = cycles since the accepting edge (0 = idle).
  int   ph = 0;
  logic m_cmd = 1'b0;
  logic m_q = 1'b0;
  logic m_mis = 1'b0;
  int   m_err = 0;

  int   rises;
  logic prev_en;
  int   en_seen;

  sr_driver #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_set   (cmd_set),
    .cmd_ready (cmd_ready),
    .s         (s),
    .r         (r),
    .en        (en),
    .q_fb      (q_fb),
    .q_exp     (q_exp),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en && s) q_latch <= 1'b1;
    else if (en && r) q_latch <= 1'b0;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_en;
    e_en = (ph >= 1) && (ph <= PW);
    chk("cmd_ready", cmd_ready, ph == 0);
    chk("en", en, e_en);
    chk("s", s, e_en & m_cmd);
    chk("r", r, e_en & ~m_cmd);
    chk("s_and_r", s & r, 1'b0);
    chk("q_exp", q_exp, m_q);
    chk("mismatch", mismatch, m_mis);
    chk_n("err_cnt", int'(err_cnt), m_err);
  endtask

  task automatic reset_model();
    ph    = 0;
    m_cmd = 1'b0;
    m_q   = 1'b0;
    m_mis = 1'b0;
    m_err = 0;
  endtask

  // mode 0: real latch feedback, 1: stuck at 0, 2: random
  task automatic cyc(input logic v, input logic st, input int mode);
    check_outputs();
    cmd_valid = v;
    cmd_set   = st;
    case (mode)
      0:       q_fb = q_latch;
      1:       q_fb = 1'b0;
      default: q_fb = 1'($urandom_range(0, 1));
    endcase
    m_mis = 1'b0;
    if (ph == 0) begin
      if (v) begin
        ph    = 1;
        m_cmd = st;
      end
    end else if (ph == CHK) begin
      if (q_fb !== m_q) begin
        m_mis = 1'b1;
        if (m_err < 255) m_err++;
      end
      ph = 0;
    end else begin
      if (ph == PW) m_q = m_cmd;
      ph++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // set command, real latch
    cyc(1'b1, 1'b1, 0);
    repeat (5) cyc(1'b0, 1'b0, 0);
    chk("q_exp_after_set", q_exp, 1'b1);

    // clear command after set
    cyc(1'b1, 1'b0, 0);
    repeat (5) cyc(1'b0, 1'b0, 0);
    chk("q_exp_after_clear", q_exp, 1'b0);
    chk_n("err_after_clear", int'(err_cnt), 0);

    // valid held with alternating type: one accept per 5 cycles
    rises   = 0;
    prev_en = en;
    for (int i = 0; i < 20; i++) begin
      if (en && !prev_en) rises++;
      prev_en = en;
      cyc(1'b1, (i % 2) == 1, 0);
    end
    chk_n("b2b_accepts", rises, 4);
    repeat (5) cyc(1'b0, 1'b0, 0);

    // valid raised in GAP/CHECK and dropped before IDLE
    cyc(1'b1, 1'b1, 0);
    cyc(1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 0);
    en_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (en || s || r) en_seen++;
      cyc(1'b0, 1'b0, 0);
    end
    chk_n("gap_valid_no_pulse", en_seen, 0);

    // fault injection: feedback stuck low after set
    cyc(1'b1, 1'b1, 1);
    repeat (4) cyc(1'b0, 1'b0, 1);
    chk("fault_mismatch", mismatch, 1'b1);
    chk_n("fault_err_1", int'(err_cnt), 1);
    for (int i = 0; i < 299; i++) begin
      cyc(1'b1, 1'b1, 1);
      repeat (4) cyc(1'b0, 1'b0, 1);
    end
    chk_n("err_saturated", int'(err_cnt), 255);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 2 : 0);
    end
    repeat (6) cyc(1'b0, 1'b0, 0);

    // reset asserted in the second DRIVE cycle
    cyc(1'b1, 1'b1, 0);
    cyc(1'b0, 1'b0, 0);
    check_outputs();
    chk("pre_reset_en", en, 1'b1);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_en", en, 1'b0);
    chk("rst_s", s, 1'b0);
    chk("rst_r", r, 1'b0);
    chk("rst_q_exp", q_exp, 1'b0);
    chk_n("rst_err_cnt", int'(err_cnt), 0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", cmd_ready, 1'b1);
    @(negedge clk);
    cyc(1'b1, 1'b0, 0);
    repeat (6) cyc(1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_driver.md
SR_DRIVER -- requirements
Module: sr_driver

Interface
REQ-001 Parameter PULSE_W, default 2: number of cycles that en and s/r are held active per command; legal range 1..15.
REQ-002 Parameter GAP_W, default 1: number of idle cycles after a pulse, with en=0 and s=r=0; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  a command is offered.
REQ-006 cmd_set  input  1  command type when cmd_valid is high: 1 = set latch, 0 = clear latch.
REQ-007 cmd_ready  output  1  the block can accept a command this cycle.
REQ-008 s  output  1  set drive to the downstream SR latch.
REQ-009 r  output  1  reset drive to the downstream SR latch.
REQ-010 en  output  1  enable drive to the downstream SR latch.
REQ-011 q_fb  input  1  q output fed back from the latch.
REQ-012 q_exp  output  1  expected latch state, derived from the last completed command.
REQ-013 mismatch  output  1  one-cycle pulse when q_fb differs from q_exp at the check point.
REQ-014 err_cnt  output  8  saturating count of mismatch events.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, DRIVE, GAP, CHECK.
REQ-016 cmd_ready SHALL equal (state==IDLE), decoded combinationally from the state register.
REQ-017 A command SHALL be accepted only on a cycle where cmd_valid=1 and cmd_ready=1; cmd_set is captured on that edge.
REQ-018 If a command is accepted at edge T:
 - s/r/en are active in cycles T+1 through T+PULSE_W;
 - GAP occupies the next GAP_W cycles;
 - CHECK occupies one cycle;
 - cmd_ready returns high in cycle T+PULSE_W+GAP_W+2.
REQ-019 In DRIVE: en=1, and s=cmd_set and r=~cmd_set from the captured command; s and r SHALL never both be 1 in any cycle.
REQ-020 In IDLE, GAP and CHECK: s=r=en=0.
REQ-021 s, r, en, q_exp, mismatch and err_cnt SHALL be registered outputs, with no combinational path from any input.
REQ-022 q_exp SHALL update to the captured cmd_set on the DRIVE->GAP transition.
REQ-023 In CHECK, q_fb SHALL be sampled and compared with q_exp; if they differ, mismatch is 1 for exactly the following cycle.
REQ-024 On each mismatch, err_cnt SHALL increment by 1 and saturate at 255 without wrapping.
REQ-025 A redundant command (set while q_exp=1, or clear while q_exp=0) SHALL be executed in full, with the same timing as any other command.
REQ-026 cmd_valid while busy SHALL be ignored without side effects; the source must hold it until it is accepted.
REQ-027 A single down-counter SHALL time both DRIVE and GAP. It is loaded with PULSE_W-1 on entry to DRIVE and with GAP_W-1 on entry to GAP, and the state advances when the counter reads 0.
REQ-028 Back-to-back commands: a command offered in the first IDLE cycle after CHECK SHALL be accepted in that cycle, with no extra bubble.

Reset
REQ-029 While rst_n=0, asynchronously and regardless of state:
 - state=IDLE and the counter is 0;
 - s=r=en=0;
 - q_exp=0, mismatch=0, err_cnt=0.
REQ-030 Reset asserted during DRIVE SHALL drop en immediately; the aborted command is lost and q_exp is not updated.
REQ-031 On the first rising edge after rst_n deasserts, the block is in IDLE with cmd_ready=1.

Structure
REQ-032 Package sr_drv_pkg SHALL hold:
 - the state enum (IDLE, DRIVE, GAP, CHECK);
 - the counter width constant (4);
 - the err_cnt width constant (8).
REQ-033 The down-counter SHALL be a sub-module named pulse_timer, with ports load, load_val, zero.
REQ-034 The block SHALL NOT instantiate the latch; the latch is connected externally at the next level up.

Verification (PULSE_W=2, GAP_W=1)
REQ-035 Set command: cmd_valid=1, cmd_set=1 accepted at edge 0 -> s=en=1 in cycles 1-2, gap in cycle 3, check in cycle 4, ready=1 in cycle 5, q_exp=1, mismatch never asserted.
REQ-036 Clear after set, q_fb tied to the real latch output -> r=en=1 for 2 cycles, s=0 throughout, q_exp=0, err_cnt stays 0.
REQ-037 Fault injection: q_fb forced to 0 after a set command -> mismatch=1 for one cycle, err_cnt=1; repeat 300 times -> err_cnt=255.
REQ-038 cmd_valid held high continuously with alternating cmd_set -> one command accepted every 5 cycles, and s&r==0 on every cycle.
REQ-039 rst_n pulled low in the second DRIVE cycle -> en=s=r=0 within the same cycle, q_exp=0, cmd_ready=1 at the first edge after release.
REQ-040 cmd_valid raised during GAP and dropped before IDLE -> no acceptance and no pulse on s/r/en.
